// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Round-robin arbiter for the single register-file write port, shared by the
// ALU (requester A) and the load unit (requester B). A pending scoreboard
// tracks destinations that have been issued but not yet written back, and it
// drives the decode-stage read-hazard stall.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              stall,
    output logic [NREG-1:0]   pending,
    output logic              err_unexp
);

    // 0 = A was granted last, 1 = B was granted last; reset to B so A wins the first tie
    logic              last_grant;
    logic              grant_a;
    logic              grant_b;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              iss_set;
    logic              hit1;
    logic              hit2;
    logic [NREG-1:0]   pending_next;

    // A tie goes to whichever requester was not served last; a lone requester always wins
    assign grant_a  = a_valid && (!b_valid || last_grant);
    assign grant_b  = b_valid && (!a_valid || !last_grant);
    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign accept   = grant_a || grant_b;
    assign win_addr = grant_a ? a_addr : b_addr;
    assign win_data = grant_a ? a_data : b_data;

    // Issue depends only on the scoreboard, never on the writeback requesters
    assign iss_ready = (iss_rd == '0) || !pending[iss_rd];
    assign iss_set   = iss_valid && iss_ready && (iss_rd != '0);

    // A register is hazardous while pending or while its write sits in the output register
    assign hit1  = (chk_addr1 != '0) &&
                   (pending[chk_addr1] || (rg_wrt_en && (rg_wrt_addr == chk_addr1)));
    assign hit2  = (chk_addr2 != '0) &&
                   (pending[chk_addr2] || (rg_wrt_en && (rg_wrt_addr == chk_addr2)));
    assign stall = hit1 || hit2;

    // Writeback clears its destination first so that a same-cycle issue to that register wins
    always_comb begin
        pending_next = pending;
        if (accept) begin
            pending_next[win_addr] = 1'b0;
        end
        if (iss_set) begin
            pending_next[iss_rd] = 1'b1;
        end
    end

    // Scoreboard, round-robin pointer and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            last_grant <= 1'b1;
            err_unexp  <= 1'b0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                last_grant <= grant_b;
            end
            if (accept && (win_addr != '0) && !pending[win_addr]) begin
                err_unexp <= 1'b1;
            end
        end
    end

    // Registered write port; writes to x0 are absorbed and address/data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else begin
            rg_wrt_en <= accept && (win_addr != '0);
            if (accept) begin
                rg_wrt_addr <= win_addr;
                rg_wrt_data <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed stimulus against regfile_wb_arbiter, with a behavioural reference
// model compared on every falling edge plus hand-computed literal checks.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        stall;
    logic [31:0] pending;
    logic        err_unexp;

    int total = 0;
    int bad   = 0;
    bit checkEn = 0;

    // Reference model state: which registers await a write, who wins the next tie,
    // and what the register file should be seeing on its write port
    bit          mPend [32];
    bit          mTieToB = 0;
    bit          mWrEn   = 0;
    logic [4:0]  mWrAddr = '0;
    logic [31:0] mWrData = '0;
    bit          mErr    = 0;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .rg_wrt_en  (rg_wrt_en),
        .rg_wrt_addr(rg_wrt_addr),
        .rg_wrt_data(rg_wrt_data),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .stall      (stall),
        .pending    (pending),
        .err_unexp  (err_unexp)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // One comparison; a mismatch prints a single FAIL line
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // 0 = nobody served, 1 = ALU served, 2 = load unit served
    function automatic int pickWinner();
        if (a_valid && b_valid) return mTieToB ? 2 : 1;
        if (a_valid) return 1;
        if (b_valid) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] modelPending();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mPend[i];
        return v;
    endfunction

    function automatic bit modelHit(input logic [4:0] r);
        return (r != 0) && (mPend[r] || (mWrEn && mWrAddr == r));
    endfunction

    // Model advances on each rising edge and is cleared the moment reset drops
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mPend[i] <= 1'b0;
            mTieToB <= 1'b0;
            mWrEn   <= 1'b0;
            mWrAddr <= '0;
            mWrData <= '0;
            mErr    <= 1'b0;
        end else begin
            if (pickWinner() != 0) begin
                if (pickWinner() == 1) begin
                    mWrEn   <= (a_addr != 0);
                    mWrAddr <= a_addr;
                    mWrData <= a_data;
                    mTieToB <= 1'b1;
                    mPend[a_addr] <= 1'b0;
                    if (a_addr != 0 && !mPend[a_addr]) mErr <= 1'b1;
                end else begin
                    mWrEn   <= (b_addr != 0);
                    mWrAddr <= b_addr;
                    mWrData <= b_data;
                    mTieToB <= 1'b0;
                    mPend[b_addr] <= 1'b0;
                    if (b_addr != 0 && !mPend[b_addr]) mErr <= 1'b1;
                end
            end else begin
                mWrEn <= 1'b0;
            end
            if (iss_valid && iss_rd != 0 && !mPend[iss_rd]) mPend[iss_rd] <= 1'b1;
        end
    end

    // Every falling edge, all outputs must agree with the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp_a_ready",   a_ready,     pickWinner() == 1);
            checkOutput("cmp_b_ready",   b_ready,     pickWinner() == 2);
            checkOutput("cmp_iss_ready", iss_ready,   (iss_rd == 0) || !mPend[iss_rd]);
            checkOutput("cmp_stall",     stall,       modelHit(chk_addr1) || modelHit(chk_addr2));
            checkOutput("cmp_pending",   pending,     modelPending());
            checkOutput("cmp_wr_en",     rg_wrt_en,   mWrEn);
            checkOutput("cmp_wr_addr",   rg_wrt_addr, mWrAddr);
            checkOutput("cmp_wr_data",   rg_wrt_data, mWrData);
            checkOutput("cmp_err",       err_unexp,   mErr);
        end
    end

    // Advance to just after the next rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic issueReg(input logic [4:0] r);
        iss_valid = 1;
        iss_rd    = r;
        applyStimulus();
        iss_valid = 0;
        iss_rd    = 0;
    endtask

    task automatic writeA(input logic [4:0] r, input logic [31:0] d);
        a_valid = 1;
        a_addr  = r;
        a_data  = d;
        applyStimulus();
        a_valid = 0;
        a_addr  = 0;
        a_data  = 0;
    endtask

    initial begin
        reset = 0;
        iss_valid = 0; iss_rd = 0;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        chk_addr1 = 0; chk_addr2 = 0;
        repeat (3) applyStimulus();
        reset   = 1;
        checkEn = 1;
        #1;
        checkOutput("rst_pending",   pending,   32'h0);
        checkOutput("rst_wr_en",     rg_wrt_en, 1'b0);
        checkOutput("rst_stall",     stall,     1'b0);
        checkOutput("rst_iss_ready", iss_ready, 1'b1);

        // Issue x5, see the hazard, write it back through A
        issueReg(5);
        checkOutput("iss5_pending", pending, 32'h20);
        chk_addr1 = 5;
        #1;
        checkOutput("iss5_stall", stall, 1'b1);
        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
        #1;
        checkOutput("wb5_a_ready", a_ready, 1'b1);
        applyStimulus();
        a_valid = 0; a_addr = 0; a_data = 0;
        #1;
        checkOutput("wb5_wr_en",    rg_wrt_en,   1'b1);
        checkOutput("wb5_wr_addr",  rg_wrt_addr, 5'd5);
        checkOutput("wb5_wr_data",  rg_wrt_data, 32'hDEADBEEF);
        checkOutput("wb5_stall",    stall,       1'b1);
        checkOutput("wb5_pending",  pending,     32'h0);
        applyStimulus();
        checkOutput("wb5_stall_clr", stall, 1'b0);
        chk_addr1 = 0;

        // A lone B writeback to x0 makes B the last grantee, so the next tie favours A
        b_valid = 1; b_addr = 0; b_data = 32'h55;
        applyStimulus();
        b_valid = 0; b_data = 0;
        issueReg(3);
        issueReg(4);
        checkOutput("iss34_pending", pending, 32'h18);
        a_valid = 1; a_addr = 3; a_data = 32'h333;
        b_valid = 1; b_addr = 4; b_data = 32'h444;
        #1;
        checkOutput("tie_a_first", a_ready, 1'b1);
        checkOutput("tie_b_wait",  b_ready, 1'b0);
        applyStimulus();
        a_valid = 0; a_addr = 0; a_data = 0;
        #1;
        checkOutput("tie_b_next", b_ready,     1'b1);
        checkOutput("wb3_addr",   rg_wrt_addr, 5'd3);
        checkOutput("wb3_data",   rg_wrt_data, 32'h333);
        applyStimulus();
        b_valid = 0; b_addr = 0; b_data = 0;
        checkOutput("wb4_addr",    rg_wrt_addr, 5'd4);
        checkOutput("wb4_data",    rg_wrt_data, 32'h444);
        checkOutput("wb34_pending", pending,    32'h0);

        // Six cycles of continuous dual requests alternate A, B, A, B, A, B
        a_valid = 1; b_valid = 1; a_addr = 0; b_addr = 0;
        for (int i = 0; i < 6; i++) begin
            a_data = i;
            b_data = 100 + i;
            #1;
            checkOutput("alt_a_ready", a_ready, (i % 2) == 0);
            checkOutput("alt_b_ready", b_ready, (i % 2) == 1);
            applyStimulus();
        end
        a_valid = 0; b_valid = 0; a_data = 0; b_data = 0;
        checkOutput("alt_last_data", rg_wrt_data, 32'd105);

        // A second issue to a pending register is refused
        issueReg(7);
        iss_valid = 1; iss_rd = 7;
        #1;
        checkOutput("iss7_refused", iss_ready, 1'b0);
        applyStimulus();
        iss_valid = 0; iss_rd = 0;
        checkOutput("iss7_pending", pending, 32'h80);

        // Writeback to x0 is accepted but never reaches the register file
        a_valid = 1; a_addr = 0; a_data = 32'h1;
        #1;
        checkOutput("x0_a_ready", a_ready, 1'b1);
        applyStimulus();
        a_valid = 0; a_data = 0;
        checkOutput("x0_wr_en", rg_wrt_en, 1'b0);
        checkOutput("x0_err",   err_unexp, 1'b0);
        writeA(7, 32'h7);

        // Unexpected writeback sets the sticky error flag
        writeA(9, 32'h99);
        checkOutput("x9_wr_en", rg_wrt_en, 1'b1);
        checkOutput("x9_err",   err_unexp, 1'b1);
        applyStimulus();
        checkOutput("x9_err_sticky", err_unexp, 1'b1);

        // Same-edge issue and writeback of x9: the issue wins
        iss_valid = 1; iss_rd = 9;
        a_valid = 1; a_addr = 9; a_data = 32'h999;
        #1;
        checkOutput("both9_iss_ready", iss_ready, 1'b1);
        checkOutput("both9_a_ready",   a_ready,   1'b1);
        applyStimulus();
        iss_valid = 0; iss_rd = 0;
        a_valid = 0; a_addr = 0; a_data = 0;
        checkOutput("both9_pending", pending,     32'h200);
        checkOutput("both9_wr_addr", rg_wrt_addr, 5'd9);
        writeA(9, 32'h9);

        // Reset in the middle of an in-flight write
        for (int r = 4; r < 8; r++) issueReg(r[4:0]);
        checkOutput("pre_rst_pending", pending, 32'hF0);
        writeA(4, 32'h44);
        checkOutput("pre_rst_wr_en", rg_wrt_en, 1'b1);
        #2;
        reset = 0;
        #1;
        checkOutput("midrst_pending", pending,   32'h0);
        checkOutput("midrst_wr_en",   rg_wrt_en, 1'b0);
        checkOutput("midrst_err",     err_unexp, 1'b0);
        applyStimulus();
        checkOutput("midrst_no_write", rg_wrt_en, 1'b0);
        reset = 1;
        a_valid = 1; b_valid = 1; a_addr = 0; b_addr = 0;
        #1;
        checkOutput("post_rst_a_wins", a_ready, 1'b1);
        checkOutput("post_rst_b_wait", b_ready, 1'b0);
        applyStimulus();
        a_valid = 0; b_valid = 0;
        applyStimulus();

        checkEn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. Two writeback requesters (ALU and load unit) compete for the single register-file write port through a valid/ready handshake with round-robin priority. A 32-bit pending scoreboard tracks destination registers issued but not yet written, and drives a stall for read hazards. The block sits between the execute/memory stages and the register-file write/read-address ports.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NREG, 32, number of registers (= 2**ADDR_W)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- iss_valid  input  1  issue stage declares a destination register
- iss_rd  input  ADDR_W  destination register being issued
- iss_ready  output  1  issue accepted this cycle
- a_valid / a_ready  input / output  1 / 1  ALU writeback handshake
- a_addr / a_data  input  ADDR_W / DATA_W  ALU writeback address and data
- b_valid / b_ready  input / output  1 / 1  load-unit writeback handshake
- b_addr / b_data  input  ADDR_W / DATA_W  load-unit writeback address and data
- rg_wrt_en  output  1  register-file write enable (registered)
- rg_wrt_addr  output  ADDR_W  register-file write address (registered)
- rg_wrt_data  output  DATA_W  register-file write data (registered)
- chk_addr1, chk_addr2  input  ADDR_W  read addresses of the instruction in decode
- stall  output  1  read hazard on chk_addr1 or chk_addr2
- pending  output  NREG  scoreboard; bit i = write to register i outstanding
- err_unexp  output  1  sticky: writeback accepted to a non-pending nonzero register

## Operation
- Issue: iss_ready = (iss_rd == 0) || !pending[iss_rd] (combinational). On iss_valid && iss_ready with iss_rd != 0, set pending[iss_rd]. Issue to x0 is accepted and changes nothing.
- Arbitration: single flop last_grant (0 = A, 1 = B).
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester not equal to last_grant.
  - a_ready / b_ready are combinational, high only for the granted requester; at most one high per cycle.
  - last_grant updates to the granted requester on every grant; unchanged when no grant.
- Accepted write (handshake of granted requester, address W, data D):
  - Next cycle: rg_wrt_en = (W != 0), rg_wrt_addr = W, rg_wrt_data = D. With no acceptance, rg_wrt_en = 0 next cycle and addr/data hold.
  - pending[W] clears at the acceptance edge.
  - If W != 0 and pending[W] == 0 at acceptance, set err_unexp (cleared only by reset).
- Simultaneous issue and acceptance: both apply on the same edge. If both target the same register, set wins. This case occurs only when pending was 0, which also flags err_unexp.
- Stall: stall = hit(chk_addr1) || hit(chk_addr2), where hit(r) = (r != 0) && (pending[r] || (rg_wrt_en && rg_wrt_addr == r)). The in-flight term covers the cycle before the register file commits the write.

## Timing
- Reset (reset low, asynchronous): pending = 0, rg_wrt_en = 0, rg_wrt_addr = 0, rg_wrt_data = 0, last_grant = 1 (A wins first tie), err_unexp = 0. Consequently stall = 0 and iss_ready = 1.
- Reset asserted mid-operation discards any in-flight write. No write reaches the register file on the following edge.
- Latency: handshake at edge N -> rg_wrt_en high during cycle N+1 -> register file holds data after edge N+1.
- Sustained throughput is one write per cycle. Under continuous dual requests, grants alternate A, B, A, B, ...
- iss_ready, a_ready, b_ready and stall are combinational from inputs and state, with no combinational path between a_valid/b_valid and iss_ready.
- Requesters must hold valid, addr and data stable until ready.

## Test plan
- Reset, then iss_rd=5 issued -> pending=0x20. chk_addr1=5 -> stall=1. A writes x5=0xDEADBEEF -> next cycle rg_wrt_en=1, addr=5, data=0xDEADBEEF, stall still 1. Following cycle stall=0, pending=0.
- Issue x3 and x4. A(x3) and B(x4) both valid every cycle -> a_ready first, b_ready next. Writes appear in order x3, x4 on consecutive cycles.
- A and B continuously valid for 6 cycles -> grants A,B,A,B,A,B. Exactly one ready per cycle.
- Issue x7 while x7 pending -> iss_ready=0, pending unchanged. Writeback to x0 with data 0x1 -> a_ready=1, rg_wrt_en stays 0, err_unexp stays 0.
- Writeback to non-pending x9 -> rg_wrt_en=1 next cycle, err_unexp=1 and sticky. Same-cycle issue of x9 with accepted write to x9 -> pending[9]=1 afterward.
- Assert reset with pending=0xF0 and a write just accepted -> pending=0, rg_wrt_en=0 immediately, no write on the next edge. After release, A wins the first tie.
